// File: rtl/spi_sram_arbiter_ctrl.sv
// SPI mode-0 master that shares a 64KB SPI SRAM between a read-only fetch port (A) and a data port (B).
// Define ARB_RR_EN for round-robin arbitration; otherwise port B has fixed priority over port A.
`timescale 1ns/1ps
module spi_sram_arbiter_ctrl #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [15:0] a_addr,
    output logic        a_ack,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic [15:0] b_rdata,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_reg, state_next;
    logic [7:0]  div_cnt_reg, div_cnt_next;
    logic [5:0]  bit_cnt_reg, bit_cnt_next;
    logic [38:0] shreg_reg, shreg_next;
    logic [15:0] rx_reg, rx_next;
    logic        port_b_reg, port_b_next;
    logic        we_reg, we_next;
    logic        cs_n_reg, cs_n_next;
    logic        sclk_reg, sclk_next;
    logic        mosi_reg, mosi_next;
    logic        a_ack_reg, a_ack_next;
    logic        b_ack_reg, b_ack_next;
    logic [15:0] a_rdata_reg, a_rdata_next;
    logic [15:0] b_rdata_reg, b_rdata_next;
    logic        busy_reg, busy_next;

    logic        grant_b;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [39:0] frame;

`ifdef ARB_RR_EN
    logic last_b_reg, last_b_next;
    // On a tie the port that did not win last time goes next.
    assign grant_b = b_req & (~a_req | ~last_b_reg);
`else
    assign grant_b = b_req;
`endif

    assign sel_addr = grant_b ? b_addr : a_addr;
    assign sel_we   = grant_b & b_we;
    // Data bytes go low byte first so the device stores little-endian at addr, addr+1.
    assign frame    = {sel_we ? 8'h02 : 8'h03, sel_addr,
                       sel_we ? {b_wdata[7:0], b_wdata[15:8]} : 16'h0000};

    always_comb begin
        state_next   = state_reg;
        div_cnt_next = div_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shreg_next   = shreg_reg;
        rx_next      = rx_reg;
        port_b_next  = port_b_reg;
        we_next      = we_reg;
        cs_n_next    = cs_n_reg;
        sclk_next    = sclk_reg;
        mosi_next    = mosi_reg;
        a_ack_next   = 1'b0;
        b_ack_next   = 1'b0;
        a_rdata_next = a_rdata_reg;
        b_rdata_next = b_rdata_reg;
        busy_next    = busy_reg;
`ifdef ARB_RR_EN
        last_b_next  = last_b_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (a_req || b_req) begin
                    port_b_next  = grant_b;
                    we_next      = sel_we;
                    shreg_next   = frame[38:0];
                    mosi_next    = frame[39];
                    cs_n_next    = 1'b0;
                    sclk_next    = 1'b0;
                    busy_next    = 1'b1;
                    div_cnt_next = 8'd0;
                    bit_cnt_next = 6'd0;
                    state_next   = SHIFT;
`ifdef ARB_RR_EN
                    last_b_next  = grant_b;
`endif
                end
            end
            SHIFT: begin
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_next = 8'd0;
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                        if (bit_cnt_reg >= 6'd24)
                            rx_next = {rx_reg[14:0], spi_miso};
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_cnt_reg == 6'd39) begin
                            mosi_next  = 1'b0;
                            state_next = HOLD;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 6'd1;
                            mosi_next    = shreg_reg[38];
                            shreg_next   = {shreg_reg[37:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 8'd1;
                end
            end
            HOLD: begin
                cs_n_next  = 1'b1;
                state_next = DONE;
                // rx holds {low byte, high byte} in arrival order.
                if (port_b_reg) begin
                    b_ack_next = 1'b1;
                    if (!we_reg)
                        b_rdata_next = {rx_reg[7:0], rx_reg[15:8]};
                end else begin
                    a_ack_next   = 1'b1;
                    a_rdata_next = {rx_reg[7:0], rx_reg[15:8]};
                end
            end
            DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            div_cnt_reg <= 8'd0;
            bit_cnt_reg <= 6'd0;
            shreg_reg   <= '0;
            rx_reg      <= 16'd0;
            port_b_reg  <= 1'b0;
            we_reg      <= 1'b0;
            cs_n_reg    <= 1'b1;
            sclk_reg    <= 1'b0;
            mosi_reg    <= 1'b0;
            a_ack_reg   <= 1'b0;
            b_ack_reg   <= 1'b0;
            a_rdata_reg <= 16'd0;
            b_rdata_reg <= 16'd0;
            busy_reg    <= 1'b0;
`ifdef ARB_RR_EN
            last_b_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shreg_reg   <= shreg_next;
            rx_reg      <= rx_next;
            port_b_reg  <= port_b_next;
            we_reg      <= we_next;
            cs_n_reg    <= cs_n_next;
            sclk_reg    <= sclk_next;
            mosi_reg    <= mosi_next;
            a_ack_reg   <= a_ack_next;
            b_ack_reg   <= b_ack_next;
            a_rdata_reg <= a_rdata_next;
            b_rdata_reg <= b_rdata_next;
            busy_reg    <= busy_next;
`ifdef ARB_RR_EN
            last_b_reg  <= last_b_next;
`endif
        end
    end

    assign a_ack    = a_ack_reg;
    assign b_ack    = b_ack_reg;
    assign a_rdata  = a_rdata_reg;
    assign b_rdata  = b_rdata_reg;
    assign busy     = busy_reg;
    assign spi_cs_n = cs_n_reg;
    assign spi_sclk = sclk_reg;
    assign spi_mosi = mosi_reg;
endmodule
